ri_mac_seq: RTL and testbench

Recurrent-input MAC sequencer. It walks the recurrent weight ROM address by address and multiplies each packed weight word by the matching hidden-state element. It accumulates UNITS_NUM parallel dot products over DEPTH addresses and hands the result vector downstream with a valid/ready handshake. It sits directly downstream of the recurrent weight ROM, which is combinational and driven by `w_addr`, and upstream of the gate activation stage.

---
 rtl/ri_mac_seq_pkg.sv | 39 +++
 rtl/ri_mac_seq_if.sv | 33 +++
 rtl/ri_mac_lane.sv | 61 ++++++
 rtl/ri_mac_seq.sv | 110 +++++++++++
 tb/tb_ri_mac_seq.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/ri_mac_seq_pkg.sv
// +--------------------------------------------------------------------------+
// | ri_mac_pkg: shared types and helpers for the recurrent-input MAC         |
// | sequencer (state enum, accumulator width, D_WL saturation).              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package ri_mac_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Working width for the saturation helper; must cover ACC_WL.
   localparam int SAT_W = 64;

   function automatic int acc_width(input int d_wl, input int frac_bits);
      return 2 * d_wl - frac_bits + 8;
   endfunction

   function automatic logic signed [SAT_W-1:0] sat_to_dwl(
      input logic signed [SAT_W-1:0] v,
      input int                      d_wl
   );
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      hi = (64'sd1 <<< (d_wl - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (d_wl - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ri_mac_seq_if.sv
// +--------------------------------------------------------------------------+
// | ri_mac_seq_if: ROM/hidden-buffer fetch and result handshake bundle for   |
// | the recurrent-input MAC sequencer.                                       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface ri_mac_seq_if #(
   parameter int D_WL      = 24,
   parameter int UNITS_NUM = 5,
   parameter int ADDR_W    = 8
);
   logic                        start;
   logic                        busy;
   logic [ADDR_W-1:0]           w_addr;
   logic [UNITS_NUM*D_WL-1:0]   w_i;
   logic [D_WL-1:0]             h_i;
   logic                        out_valid;
   logic                        out_ready;
   logic [UNITS_NUM*D_WL-1:0]   result_o;

   modport master (
      output start, w_i, h_i, out_ready,
      input  busy, w_addr, out_valid, result_o
   );

   modport slave (
      input  start, w_i, h_i, out_ready,
      output busy, w_addr, out_valid, result_o
   );
endinterface

`default_nettype wire

// File: rtl/ri_mac_lane.sv
// +--------------------------------------------------------------------------+
// | ri_mac_lane: one lane of product register, fixed-point shift,            |
// | accumulator and output fit. Output fit clamps when RI_MAC_SAT_EN.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module ri_mac_lane
   import ri_mac_pkg::*;
#(
   parameter int D_WL      = 24,
   parameter int FRAC_BITS = 12,
   parameter int ACC_WL    = acc_width(24, 12)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   input  logic                   prod_en,
   input  logic                   acc_en,
   input  logic                   load,
   input  logic signed [D_WL-1:0] w,
   input  logic signed [D_WL-1:0] h,
   output logic [D_WL-1:0]        result
);

   logic signed [2*D_WL-1:0] w_prod;
   logic [D_WL-1:0]          w_fit;
   logic signed [ACC_WL-1:0] r_prod;
   logic signed [ACC_WL-1:0] r_acc;
   logic [D_WL-1:0]          r_result;

   assign w_prod = (2*D_WL)'(w) * (2*D_WL)'(h);

`ifdef RI_MAC_SAT_EN
   assign w_fit = D_WL'(sat_to_dwl(SAT_W'(r_acc), D_WL));
`else
   assign w_fit = r_acc[D_WL-1:0];
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_prod   <= '0;
         r_acc    <= '0;
         r_result <= '0;
      end else begin
         if (prod_en)
            r_prod <= ACC_WL'(w_prod >>> FRAC_BITS);
         if (clear)
            r_acc <= '0;
         else if (acc_en)
            r_acc <= r_acc + r_prod;
         if (load)
            r_result <= w_fit;
      end
   end

   assign result = r_result;

endmodule

`default_nettype wire

// File: rtl/ri_mac_seq.sv
// +--------------------------------------------------------------------------+
// | ri_mac_seq: walks the recurrent weight ROM, accumulates UNITS_NUM dot    |
// | products over DEPTH addresses and presents them with valid/ready.        |
// | Build option: RI_MAC_SAT_EN (clamp result lanes to signed D_WL).         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module ri_mac_seq
   import ri_mac_pkg::*;
#(
   parameter int D_WL      = 24,
   parameter int UNITS_NUM = 5,
   parameter int DEPTH     = 180,
   parameter int ADDR_W    = 8,
   parameter int FRAC_BITS = 12,
   parameter int ACC_WL    = acc_width(D_WL, FRAC_BITS)
) (
   input  logic          clk,
   input  logic          rst_n,
   ri_mac_seq_if.slave   bus
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [ADDR_W-1:0]         r_cnt;
   logic                      r_drain;
   logic                      r_prod_valid;
   logic                      w_clear;
   logic                      w_load;
   logic                      w_run;
   logic [UNITS_NUM*D_WL-1:0] w_res;

   assign w_run = (r_state == ST_RUN);

   always_comb begin
      w_state_nxt = r_state;
      w_clear     = 1'b0;
      w_load      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_state_nxt = ST_RUN;
               w_clear     = 1'b1;
            end
         end
         ST_RUN: begin
            if (r_cnt == LAST_ADDR)
               w_state_nxt = ST_DRAIN;
         end
         // Second drain cycle: the last product has just been accumulated.
         ST_DRAIN: begin
            if (r_drain) begin
               w_state_nxt = ST_DONE;
               w_load      = 1'b1;
            end
         end
         ST_DONE: begin
            if (bus.out_ready)
               w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_drain      <= 1'b0;
         r_prod_valid <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_prod_valid <= w_run;
         r_drain      <= (r_state == ST_DRAIN) ? ~r_drain : 1'b0;
         if (w_clear || (w_run && r_cnt == LAST_ADDR))
            r_cnt <= '0;
         else if (w_run)
            r_cnt <= r_cnt + 1'b1;
      end
   end

   for (genvar u = 0; u < UNITS_NUM; u++) begin : g_lane
      ri_mac_lane #(
         .D_WL      (D_WL),
         .FRAC_BITS (FRAC_BITS),
         .ACC_WL    (ACC_WL)
      ) u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .clear   (w_clear),
         .prod_en (w_run),
         .acc_en  (r_prod_valid),
         .load    (w_load),
         .w       (bus.w_i[u*D_WL +: D_WL]),
         .h       (bus.h_i),
         .result  (w_res[u*D_WL +: D_WL])
      );
   end

   assign bus.busy      = w_run || (r_state == ST_DRAIN);
   assign bus.w_addr    = w_run ? r_cnt : '0;
   assign bus.out_valid = (r_state == ST_DONE);
   assign bus.result_o  = w_res;

endmodule

`default_nettype wire

// File: tb/tb_ri_mac_seq.sv
// +--------------------------------------------------------------------------+
// | tb_ri_mac_seq: directed and random runs of ri_mac_seq against an         |
// | arithmetic dot-product model. Honours RI_MAC_SAT_EN.                      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ri_mac_seq;

   localparam int D_WL      = 24;
   localparam int UNITS_NUM = 5;
   localparam int DEPTH     = 180;
   localparam int ADDR_W    = 8;
   localparam int FRAC_BITS = 12;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ri_mac_seq_if #(.D_WL(D_WL), .UNITS_NUM(UNITS_NUM), .ADDR_W(ADDR_W)) bus ();

   ri_mac_seq #(
      .D_WL(D_WL), .UNITS_NUM(UNITS_NUM), .DEPTH(DEPTH),
      .ADDR_W(ADDR_W), .FRAC_BITS(FRAC_BITS)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic signed [D_WL-1:0] rom [DEPTH][UNITS_NUM];
   logic signed [D_WL-1:0] hid [DEPTH];

   // Combinational ROM and hidden buffer, both indexed by w_addr.
   always_comb begin
      bus.w_i = '0;
      bus.h_i = '0;
      if (int'(bus.w_addr) < DEPTH) begin
         for (int u = 0; u < UNITS_NUM; u++)
            bus.w_i[u*D_WL +: D_WL] = rom[bus.w_addr][u];
         bus.h_i = hid[bus.w_addr];
      end
   end

   int ncmp  = 0;
   int nfail = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Dot product of lane u over the whole table, then fitted to D_WL.
   function automatic logic [D_WL-1:0] model_lane(input int u);
      longint acc = 0;
      for (int k = 0; k < DEPTH; k++)
         acc += (longint'(rom[k][u]) * longint'(hid[k])) >>> FRAC_BITS;
`ifdef RI_MAC_SAT_EN
      if (acc > longint'(8388607))  acc = 8388607;
      if (acc < longint'(-8388608)) acc = -8388608;
`endif
      return acc[D_WL-1:0];
   endfunction

   // mode 0: all weights wv; mode 1: lane u = u*0x100; mode 2: random.
   task automatic fill(input int mode, input logic [D_WL-1:0] wv, input logic [D_WL-1:0] hv);
      for (int k = 0; k < DEPTH; k++) begin
         hid[k] = (mode == 2) ? D_WL'($urandom) : hv;
         for (int u = 0; u < UNITS_NUM; u++)
            rom[k][u] = (mode == 0) ? wv : (mode == 1) ? D_WL'(u * 32'h100) : D_WL'($urandom);
      end
   endtask

   // lit_mode 0: model only; 1: every lane == lit; 2: lane u == u*lit.
   task automatic run_and_check(input string tag, input bit ready_now,
                                input int lit_mode, input logic [D_WL-1:0] lit);
      int lat;
      int busy_bad;
      int addr_bad;
      logic [ADDR_W-1:0] addr_q[$];
      logic [UNITS_NUM*D_WL-1:0] res;
      @(negedge clk) bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat = 0;
      busy_bad = 0;
      addr_bad = 0;
      while (bus.out_valid !== 1'b1 && lat < 400) begin
         addr_q.push_back(bus.w_addr);
         if (bus.busy !== 1'b1) busy_bad++;
         bus.start = ($urandom_range(0, 3) == 0);
         @(posedge clk); #1;
         lat++;
      end
      bus.start = 1'b0;
      check({tag, " latency"}, 64'(lat), 64'(DEPTH + 2));
      check({tag, " busy during run"}, 64'(busy_bad), 64'd0);
      check({tag, " busy after"}, 64'(bus.busy), 64'd0);
      for (int j = 0; j < addr_q.size(); j++)
         if (int'(addr_q[j]) != ((j < DEPTH) ? j : 0)) addr_bad++;
      check({tag, " addr sweep"}, 64'(addr_bad), 64'd0);
      res = bus.result_o;
      for (int u = 0; u < UNITS_NUM; u++) begin
         check($sformatf("%s lane%0d", tag, u), 64'(res[u*D_WL +: D_WL]), 64'(model_lane(u)));
         if (lit_mode == 1)
            check($sformatf("%s lane%0d lit", tag, u), 64'(res[u*D_WL +: D_WL]), 64'(lit));
         else if (lit_mode == 2)
            check($sformatf("%s lane%0d lit", tag, u), 64'(res[u*D_WL +: D_WL]),
                  64'(D_WL'(u * int'(lit))));
      end
      if (ready_now) begin
         @(posedge clk); #1;
         check({tag, " accepted"}, 64'(bus.out_valid), 64'd0);
      end
   endtask

   initial begin
      logic [UNITS_NUM*D_WL-1:0] held;
      int hold_bad;
      bus.start     = 1'b0;
      bus.out_ready = 1'b1;
      fill(0, 24'h000800, 24'h001000);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset busy", 64'(bus.busy), 64'd0);
      check("reset w_addr", 64'(bus.w_addr), 64'd0);
      check("reset out_valid", 64'(bus.out_valid), 64'd0);
      check("reset result", 64'(bus.result_o), 64'd0);
      @(negedge clk) rst_n = 1'b1;

      run_and_check("nominal", 1'b1, 1, 24'h05A000);

      fill(0, 24'h000800, 24'hFFF000);
      run_and_check("negative", 1'b1, 1, 24'hFA6000);

      fill(1, 24'h0, 24'h000400);
      run_and_check("lane order", 1'b1, 2, 24'h002D00);

      fill(0, 24'h100000, 24'h100000);
`ifdef RI_MAC_SAT_EN
      run_and_check("saturation", 1'b1, 1, 24'h7FFFFF);
`else
      run_and_check("saturation", 1'b1, 1, 24'h000000);
`endif

      for (int r = 0; r < 3; r++) begin
         fill(2, 24'h0, 24'h0);
         run_and_check($sformatf("random%0d", r), 1'b1, 0, 24'h0);
      end

      // Backpressure: results must hold and start must be ignored.
      fill(0, 24'h000800, 24'h001000);
      bus.out_ready = 1'b0;
      run_and_check("backpressure", 1'b0, 1, 24'h05A000);
      held = bus.result_o;
      hold_bad = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk) bus.start = c[0];
         @(posedge clk); #1;
         if (bus.out_valid !== 1'b1 || bus.result_o !== held || bus.busy !== 1'b0) hold_bad++;
      end
      check("backpressure hold", 64'(hold_bad), 64'd0);
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.start     = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("bp accept valid", 64'(bus.out_valid), 64'd0);
      check("bp accept busy", 64'(bus.busy), 64'd0);
      @(posedge clk); #1;
      check("bp start ignored", 64'(bus.busy), 64'd0);
      run_and_check("after bp", 1'b1, 1, 24'h05A000);

      // Reset in the middle of a run discards it.
      fill(2, 24'h0, 24'h0);
      @(negedge clk) bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (49) @(posedge clk);
      @(negedge clk) rst_n = 1'b0;
      @(posedge clk); #1;
      check("midrst busy", 64'(bus.busy), 64'd0);
      check("midrst w_addr", 64'(bus.w_addr), 64'd0);
      check("midrst out_valid", 64'(bus.out_valid), 64'd0);
      check("midrst result", 64'(bus.result_o), 64'd0);
      @(negedge clk) rst_n = 1'b1;
      fill(0, 24'h000800, 24'h001000);
      run_and_check("after midrst", 1'b1, 1, 24'h05A000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
